esop_seq_eval: RTL and testbench

Sequential, programmable evaluator for exclusive-sum-of-products (ESOP) functions. It accepts a binary input vector over a valid/ready handshake and walks a locally stored cube list, one cube per clock, XOR-accumulating cube matches. It returns the single-bit function value over a second valid/ready handshake. It sits next to the flat combinational ESOP benchmark netlists and is driven by the same input vectors, so any benchmark cube list loaded into it must reproduce that netlist's output bit-for-bit.

---
 rtl/esop_seq_eval.sv | 172 +++++++++++++++++
 tb/tb_esop_seq_eval.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esop_seq_eval.sv
// rtl/esop_seq_eval.sv - sequential programmable ESOP evaluator, one cube per cycle (two with ESOP_PAR2_EN)
//
// Optional feature macro: ESOP_PAR2_EN (evaluate two cubes per EVAL cycle).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_mask/cfg_pol   cube write (IDLE only)
//   cfg_n_we/cfg_ncubes        active cube count write (IDLE only, clamped to MAX_CUBES)
//   in_valid/in_ready/in_x     input vector handshake
//   out_valid/out_ready/out_o  result handshake
//   busy                       high while a transaction is in flight (EVAL or DONE)

module esop_seq_eval #(
    parameter int NVARS     = 21,
    parameter int MAX_CUBES = 32,
    parameter int CIDX_W    = $clog2(MAX_CUBES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CIDX_W-1:0] cfg_addr,
    input  logic [NVARS-1:0]  cfg_mask,
    input  logic [NVARS-1:0]  cfg_pol,
    input  logic              cfg_n_we,
    input  logic [CIDX_W:0]   cfg_ncubes,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NVARS-1:0]  in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_o,
    output logic              busy
);

    localparam int NW = CIDX_W + 1;

`ifdef ESOP_PAR2_EN
    localparam logic [NW-1:0] STEP = NW'(2);
`else
    localparam logic [NW-1:0] STEP = NW'(1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [NVARS-1:0] mask_mem [MAX_CUBES];
    logic [NVARS-1:0] pol_mem  [MAX_CUBES];
    logic [NW-1:0]    n_cubes;
    logic [NVARS-1:0] x_lat;
    logic [NW-1:0]    idx;
    logic             acc;

    logic             hit_a;
    logic             hit_b;
    logic             last_step;

    function automatic logic cube_match(input logic [NVARS-1:0] x,
                                        input logic [NVARS-1:0] m,
                                        input logic [NVARS-1:0] p);
        return &((x ~^ p) | ~m);
    endfunction

    // Slots beyond N contribute nothing; this also lets N=0 pass through a
    // single empty EVAL cycle so the latency is never below one cycle.
    assign hit_a = (idx < n_cubes) &&
                   cube_match(x_lat, mask_mem[idx[CIDX_W-1:0]], pol_mem[idx[CIDX_W-1:0]]);

`ifdef ESOP_PAR2_EN
    logic [NW-1:0] idx_b;
    assign idx_b = idx + NW'(1);
    assign hit_b = (idx_b < n_cubes) &&
                   cube_match(x_lat, mask_mem[idx_b[CIDX_W-1:0]], pol_mem[idx_b[CIDX_W-1:0]]);
`else
    assign hit_b = 1'b0;
`endif

    assign last_step = ((idx + STEP) >= n_cubes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_o     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_o     = acc;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Cube storage; writes land on the accept edge too, so the vector being
    // accepted is evaluated against the freshly written contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CUBES; i++) begin
                mask_mem[i] <= '0;
                pol_mem[i]  <= '0;
            end
            n_cubes <= '0;
        end else if (state == IDLE) begin
            if (cfg_we && (32'(cfg_addr) < MAX_CUBES)) begin
                mask_mem[cfg_addr] <= cfg_mask;
                pol_mem[cfg_addr]  <= cfg_pol;
            end
            if (cfg_n_we) begin
                if (32'(cfg_ncubes) > MAX_CUBES) begin
                    n_cubes <= NW'(MAX_CUBES);
                end else begin
                    n_cubes <= cfg_ncubes;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat <= '0;
            acc   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_lat <= in_x;
                        acc   <= 1'b0;
                        idx   <= '0;
                    end
                end
                EVAL: begin
                    acc <= acc ^ hit_a ^ hit_b;
                    idx <= idx + STEP;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esop_seq_eval.sv
// tb/tb_esop_seq_eval.sv - self-checking bench for esop_seq_eval against a cube-list reference model

module tb_esop_seq_eval;

    localparam int NV = 21;
    localparam int MC = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [NV-1:0] cfg_mask;
    logic [NV-1:0] cfg_pol;
    logic          cfg_n_we;
    logic [5:0]    cfg_ncubes;
    logic          in_valid;
    logic          in_ready;
    logic [NV-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic          out_o;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [NV-1:0] m_mask [MC];
    logic [NV-1:0] m_pol  [MC];
    int            m_n;

    always #5 clk = ~clk;

    esop_seq_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_pol    (cfg_pol),
        .cfg_n_we   (cfg_n_we),
        .cfg_ncubes (cfg_ncubes),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_o      (out_o),
        .busy       (busy)
    );

    // Reference: a cube holds when every literal it contains agrees with x.
    function automatic logic model_eval(input logic [NV-1:0] x);
        logic r = 1'b0;
        for (int c = 0; c < m_n; c++) begin
            if (((x ^ m_pol[c]) & m_mask[c]) == '0) r = ~r;
        end
        return r;
    endfunction

    function automatic int exp_lat(input int n);
        int l;
`ifdef ESOP_PAR2_EN
        l = (n + 1) / 2;
`else
        l = n;
`endif
        return (l < 1) ? 1 : l;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < MC; c++) begin
            m_mask[c] = '0;
            m_pol[c]  = '0;
        end
        m_n = 0;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_addr = '0; cfg_mask = '0; cfg_pol = '0;
        cfg_n_we = 0; cfg_ncubes = '0; in_valid = 0; in_x = '0; out_ready = 0;
    endtask

    task automatic cfg_cube(input int a, input logic [NV-1:0] m, input logic [NV-1:0] p);
        cfg_we = 1; cfg_addr = 5'(a); cfg_mask = m; cfg_pol = p;
        @(posedge clk); #1;
        cfg_we = 0;
        m_mask[a] = m;
        m_pol[a]  = p;
    endtask

    task automatic cfg_n(input int n);
        cfg_n_we = 1; cfg_ncubes = 6'(n);
        @(posedge clk); #1;
        cfg_n_we = 0;
        m_n = (n > MC) ? MC : n;
    endtask

    // Waits (bounded) for out_valid after an accept edge; lat counts edges.
    task automatic wait_result(output logic res, inout int lat);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_o;
    endtask

    task automatic run_txn(input logic [NV-1:0] x, output logic res, output int lat);
        in_valid = 1; in_x = x;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        wait_result(res, lat);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_o !== 1'b0) begin bad++; $display("FAIL reset_out_o got=%b exp=0", out_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        logic r; int l;
        run_txn('0, r, l);
        total++; if (r !== 1'b0) begin bad++; $display("FAIL empty_out got=%b exp=0", r); end
        total++; if (l != 1) begin bad++; $display("FAIL empty_lat got=%0d exp=1", l); end
        total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL empty_after got=busy%b/rdy%b/ov%b exp=busy0/rdy1/ov0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        logic r; int l;
        cfg_cube(0, 21'h20, 21'h20);
        cfg_n(1);
        run_txn(21'h20, r, l);
        total++; if (r !== 1'b1) begin bad++; $display("FAIL single_x5_hi got=%b exp=1", r); end
        total++; if (l != 1) begin bad++; $display("FAIL single_lat_hi got=%0d exp=1", l); end
        run_txn(21'h0, r, l);
        total++; if (r !== 1'b0) begin bad++; $display("FAIL single_x5_lo got=%b exp=0", r); end
        total++; if (l != 1) begin bad++; $display("FAIL single_lat_lo got=%0d exp=1", l); end
    endtask

    task automatic test_two();
        logic r; int l;
        cfg_cube(0, 21'h0, 21'h0);
        cfg_cube(1, 21'h4100, 21'h4100);
        cfg_n(2);
        run_txn(21'h4100, r, l);
        total++; if (r !== 1'b0) begin bad++; $display("FAIL two_both got=%b exp=0", r); end
        total++; if (l != exp_lat(2)) begin bad++; $display("FAIL two_lat got=%0d exp=%0d", l, exp_lat(2)); end
        run_txn(21'h100, r, l);
        total++; if (r !== 1'b1) begin bad++; $display("FAIL two_const got=%b exp=1", r); end
    endtask

    task automatic test_backpressure();
        logic r; int l;
        in_valid = 1; in_x = 21'h100;
        @(posedge clk); #1;
        in_valid = 0;
        l = 0;
        wait_result(r, l);
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_o !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=ov%b/o%b/rdy%b exp=ov1/o1/rdy0", i, out_valid, out_o, in_ready);
            end
            in_valid = (i == 2); in_x = 21'h4100;
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=ov%b/rdy%b exp=ov0/rdy1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept got busy=%b exp=0", busy); end
    endtask

    task automatic test_cfg_busy();
        logic r; int l; logic exp; logic [NV-1:0] x;
        x = NV'($urandom);
        cfg_cube(0, 21'h0, 21'h0);
        for (int c = 1; c < 8; c++) cfg_cube(c, NV'($urandom & $urandom), NV'($urandom));
        cfg_n(8);
        exp = model_eval(x);
        in_valid = 1; in_x = x;
        @(posedge clk); #1;
        in_valid = 0;
        cfg_we = 1; cfg_addr = 5'd0; cfg_mask = '1; cfg_pol = ~x;
        cfg_n_we = 1; cfg_ncubes = 6'd3;
        @(posedge clk); #1;
        cfg_we = 0; cfg_n_we = 0;
        l = 1;
        wait_result(r, l);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (r !== exp) begin bad++; $display("FAIL busy_cfg_result got=%b exp=%b", r, exp); end
        total++; if (l != exp_lat(8)) begin bad++; $display("FAIL busy_cfg_lat got=%0d exp=%0d", l, exp_lat(8)); end
        run_txn(x, r, l);
        total++; if (r !== exp || l != exp_lat(8)) begin
            bad++; $display("FAIL busy_cfg_kept got=%b/%0d exp=%b/%0d", r, l, exp, exp_lat(8));
        end
    endtask

    task automatic test_clamp();
        logic r; int l;
        for (int c = 0; c < MC; c++) cfg_cube(c, 21'h0, 21'h0);
        cfg_n(40);
        run_txn(NV'($urandom), r, l);
        total++; if (r !== 1'b0) begin bad++; $display("FAIL clamp_out got=%b exp=0", r); end
        total++; if (l != exp_lat(32)) begin bad++; $display("FAIL clamp_lat got=%0d exp=%0d", l, exp_lat(32)); end
        cfg_n(31);
        run_txn(NV'($urandom), r, l);
        total++; if (r !== 1'b1 || l != exp_lat(31)) begin
            bad++; $display("FAIL n31 got=%b/%0d exp=1/%0d", r, l, exp_lat(31));
        end
    endtask

    task automatic test_simul_cfg();
        logic r; int l;
        cfg_cube(0, '1, '1);
        cfg_n(0);
        cfg_we = 1; cfg_addr = 5'd0; cfg_mask = '0; cfg_pol = '0;
        cfg_n_we = 1; cfg_ncubes = 6'd1;
        in_valid = 1; in_x = '0;
        @(posedge clk); #1;
        cfg_we = 0; cfg_n_we = 0; in_valid = 0;
        m_mask[0] = '0; m_pol[0] = '0; m_n = 1;
        l = 0;
        wait_result(r, l);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (r !== 1'b1 || l != 1) begin bad++; $display("FAIL simul_cfg got=%b/%0d exp=1/1", r, l); end
    endtask

    task automatic test_random();
        logic r; int l; logic [NV-1:0] x; int c;
        for (int round = 0; round < 6; round++) begin
            for (int k = 0; k < MC; k++) cfg_cube(k, NV'($urandom & $urandom & $urandom), NV'($urandom));
            cfg_n((round == 0) ? 0 : (round == 1) ? 32 : $urandom_range(1, 33));
            for (int v = 0; v < 8; v++) begin
                c = $urandom_range(0, MC - 1);
                x = (v[0]) ? NV'($urandom) : ((m_pol[c] & m_mask[c]) | (NV'($urandom) & ~m_mask[c]));
                run_txn(x, r, l);
                total++; if (r !== model_eval(x)) begin
                    bad++; $display("FAIL rand_val r=%0d v=%0d x=%h got=%b exp=%b", round, v, x, r, model_eval(x));
                end
                total++; if (l != exp_lat(m_n)) begin
                    bad++; $display("FAIL rand_lat r=%0d n=%0d got=%0d exp=%0d", round, m_n, l, exp_lat(m_n));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic r; int l;
        for (int c = 0; c < 3; c++) cfg_cube(c, 21'h0, 21'h0);
        cfg_n(3);
        in_valid = 1; in_x = '0;
        @(posedge clk); #1;
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_o !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=rdy%b/ov%b/o%b/busy%b exp=rdy1/ov0/o0/busy0", in_ready, out_valid, out_o, busy);
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
        run_txn('1, r, l);
        total++; if (r !== 1'b0 || l != 1) begin bad++; $display("FAIL mid_cleared got=%b/%0d exp=0/1", r, l); end
        cfg_cube(0, 21'h20, 21'h20);
        cfg_n(1);
        run_txn(21'h20, r, l);
        total++; if (r !== 1'b1) begin bad++; $display("FAIL mid_reprog got=%b exp=1", r); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_empty();
        test_single();
        test_two();
        test_backpressure();
        test_cfg_busy();
        test_clamp();
        test_simul_cfg();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
